// File: rtl/gci_std_display_vram_writer_pkg.sv
// Shared definitions for the display VRAM write path.
package gci_std_display_parameter;

  localparam int PL_MEM_ADDR_N = 23;

  typedef enum logic [1:0] {
    L_ST_IDLE   = 2'd0,
    L_ST_REQ    = 2'd1,
    L_ST_WRITE  = 2'd2,
    L_ST_FINISH = 2'd3
  } t_wr_state;

endpackage

// File: rtl/gci_std_display_sync_fifo.sv
// Single-clock FIFO with occupancy count; head reads as zero when empty.
module gci_std_display_sync_fifo #(
  parameter int P_N       = 55,
  parameter int P_DEPTH_N = 4
)(
  input  logic               iCLOCK,
  input  logic               inRESET,
  input  logic               iRESET_SYNC,
  input  logic               iWR_EN,
  input  logic [P_N-1:0]     iWR_DATA,
  output logic               oWR_FULL,
  input  logic               iRD_EN,
  output logic [P_N-1:0]     oRD_DATA,
  output logic               oRD_EMPTY,
  output logic [P_DEPTH_N:0] oCOUNT
);

  localparam logic [P_DEPTH_N:0] L_DEPTH = {1'b1, {P_DEPTH_N{1'b0}}};

  logic [P_N-1:0]       r_mem [0:(2**P_DEPTH_N)-1];
  logic [P_DEPTH_N-1:0] r_wp;
  logic [P_DEPTH_N-1:0] r_rp;
  logic [P_DEPTH_N:0]   r_cnt;
  logic                 w_push;
  logic                 w_pop;

  assign oWR_FULL  = (r_cnt == L_DEPTH);
  assign oRD_EMPTY = (r_cnt == '0);
  assign oCOUNT    = r_cnt;
  // A push while full is dropped even if a pop happens in the same cycle.
  assign w_push    = iWR_EN && !oWR_FULL;
  assign w_pop     = iRD_EN && !oRD_EMPTY;
  assign oRD_DATA  = oRD_EMPTY ? '0 : r_mem[r_rp];

  // Pointer and occupancy tracking; pointers wrap naturally at the depth.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (iRESET_SYNC) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge iCLOCK) begin
    if (w_push) r_mem[r_wp] <= iWR_DATA;
  end

endmodule

// File: rtl/gci_std_display_vram_writer.sv
// Buffers pixel writes and drains them to the VRAM interface in bursts.
//
// state  | meaning
// IDLE   | nothing granted; request once the FIFO holds data
// REQ    | oIF_REQ high, waiting for iIF_ACK
// WRITE  | granted; one word per cycle unless stalled or preempted
// FINISH | one-cycle oIF_FINISH, grant released
module gci_std_display_vram_writer
  import gci_std_display_parameter::*;
#(
  parameter int P_MEM_ADDR_N   = PL_MEM_ADDR_N,
  parameter int P_FIFO_DEPTH_N = 4,
  parameter int P_BURST_MAX    = 8
)(
  input  logic                    iCLOCK,
  input  logic                    inRESET,
  input  logic                    iRESET_SYNC,
  input  logic                    iWR_REQ,
  output logic                    oWR_BUSY,
  input  logic [P_MEM_ADDR_N-1:0] iWR_ADDR,
  input  logic [31:0]             iWR_DATA,
  output logic                    oIF_REQ,
  input  logic                    iIF_ACK,
  output logic                    oIF_FINISH,
  input  logic                    iIF_BREAK,
  output logic                    oIF_ENA,
  input  logic                    iIF_BUSY,
  output logic                    oIF_RW,
  output logic [P_MEM_ADDR_N-1:0] oIF_ADDR,
  output logic [31:0]             oIF_DATA
);

  localparam int                   L_BURST_W = $clog2(P_BURST_MAX + 1);
  localparam logic [P_FIFO_DEPTH_N:0] L_ONE  = {{P_FIFO_DEPTH_N{1'b0}}, 1'b1};

  t_wr_state                   r_state;
  t_wr_state                   w_state_next;
  logic [L_BURST_W-1:0]        r_burst;
  logic [P_FIFO_DEPTH_N:0]     w_count;
  logic                        w_empty;
  logic                        w_push;
  logic                        w_ena;
  logic                        w_empty_next;
  logic                        w_burst_last;
  logic [P_MEM_ADDR_N+31:0]    w_head;

  gci_std_display_sync_fifo #(
    .P_N       (P_MEM_ADDR_N + 32),
    .P_DEPTH_N (P_FIFO_DEPTH_N)
  ) u_fifo (
    .iCLOCK      (iCLOCK),
    .inRESET     (inRESET),
    .iRESET_SYNC (iRESET_SYNC),
    .iWR_EN      (iWR_REQ),
    .iWR_DATA    ({iWR_ADDR, iWR_DATA}),
    .oWR_FULL    (oWR_BUSY),
    .iRD_EN      (w_ena),
    .oRD_DATA    (w_head),
    .oRD_EMPTY   (w_empty),
    .oCOUNT      (w_count)
  );

  assign w_push       = iWR_REQ && !oWR_BUSY;
  assign w_ena        = (r_state == L_ST_WRITE) && !w_empty && !iIF_BUSY && !iIF_BREAK;
  // Occupancy after this edge is zero; a same-cycle push keeps the burst alive.
  assign w_empty_next = !w_push && ((w_count == '0) || (w_count == L_ONE && w_ena));
  assign w_burst_last = w_ena && (r_burst == L_BURST_W'(P_BURST_MAX - 1));

  assign oIF_ENA    = w_ena;
  assign oIF_REQ    = (r_state == L_ST_REQ);
  assign oIF_FINISH = (r_state == L_ST_FINISH);
  assign oIF_RW     = 1'b1;
  assign oIF_ADDR   = w_head[P_MEM_ADDR_N+31:32];
  assign oIF_DATA   = w_head[31:0];

  // State register; any reset drops the grant silently.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)         r_state <= L_ST_IDLE;
    else if (iRESET_SYNC) r_state <= L_ST_IDLE;
    else                  r_state <= w_state_next;
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      L_ST_IDLE:   if (w_count != '0) w_state_next = L_ST_REQ;
      L_ST_REQ:    if (iIF_ACK) w_state_next = L_ST_WRITE;
      L_ST_WRITE:  if (iIF_BREAK || w_empty_next || w_burst_last) w_state_next = L_ST_FINISH;
      L_ST_FINISH: w_state_next = L_ST_IDLE;
      default:     w_state_next = L_ST_IDLE;
    endcase
  end

  // Words written in the current grant; restarted on every new grant.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)                               r_burst <= '0;
    else if (iRESET_SYNC)                       r_burst <= '0;
    else if (r_state == L_ST_REQ && iIF_ACK)    r_burst <= '0;
    else if (w_ena)                             r_burst <= r_burst + L_BURST_W'(1);
  end

endmodule
